args_counter_sched: RTL and testbench
=====================================

// Module: args_counter_sched
// PURPOSE
//  Window scheduler for an args_counter bank of N W-bit event counters.
//  Ends a counting window periodically, or on demand, by pulsing the bank clear and capturing all N counts into a shadow register.
//  Streams the captured counts out one word per beat on a valid/ready interface toward the register/DMA readout path.
//  Sits beside the counter bank; owns its clr input exclusively.
// PARAMETERS
//  N   2   number of counters in the bank (>=1)
//  W   32  counter / window-length width, bits
//  IW  (localparam) N>1 ? $clog2(N) : 1; index width
// PORTS
//  clk       in   1      clock
//  rst_n     in   1      async active-low reset
//  en        in   1      1 = periodic windows run; 0 = timer held at 0
//  win_len   in   W      window length in cycles; 0 = periodic windows disabled
//  snap_req  in   1      1-cycle pulse: end the current window now
//  counters  in   N*W    counter bank values, counter i at [i*W+:W]
//  cnt_clr   out  1      to bank clr; registered 1-cycle pulse
//  m_valid   out  1      stream word valid
//  m_ready   in   1      stream sink ready
//  m_data    out  W      shadow word m_idx
//  m_idx     out  IW     counter index of current word
//  m_last    out  1      1 when m_idx==N-1 (qualified by m_valid)
//  busy      out  1      1 while in SEND
//  ovf_cnt   out  16     count of dropped snapshots, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset:
//   - rst_n low asynchronously clears timer, shadow, state (IDLE) and all outputs to 0.
//   - A stream in progress is aborted with no m_last beat.
//  Timer:
//   - If en=0 or win_len=0, timer <= 0.
//   - Otherwise timer increments each cycle; the cycle with timer==win_len-1 is a window event and timer <= 0.
//   - win_len changes take effect on the next compare. If win_len drops to <= timer, the timer runs on and the event fires only after W-bit wrap; software must change win_len with en=0.
//  Event E:
//   - Fires on the timer terminal count or on snap_req=1, independent of en.
//   - Both in the same cycle = one event.
//   - snap_req also restarts the timer at 0.
//  At the edge ending event cycle E:
//   - cnt_clr <= 1 for exactly cycle E+1. Always issued, even if snapshot dropped.
//   - If state==IDLE: shadow <= counters, state <= SEND, m_idx <= 0, m_valid <= 1 in cycle E+1.
//   - If state==SEND: shadow and stream unchanged; ovf_cnt <= sat(ovf_cnt+1).
//  Blind gap: plus events of cycles E and E+1 land in no window. This is accepted; window counts are exact otherwise.
//  FSM:
//   - IDLE: m_valid=0; go to SEND on event.
//   - SEND: m_valid=1; m_data=shadow[m_idx*W+:W].
//     - On m_valid&&m_ready with m_idx<N-1: m_idx++.
//     - With m_idx==N-1: state <= IDLE, m_valid <= 0, m_idx <= 0.
//  Handshake:
//   - m_data, m_idx and m_last are held stable while m_valid && !m_ready.
//   - m_valid never drops without a handshake, except on reset.
//   - A stream takes at least N cycles. An event on the same cycle as the final handshake counts as an overflow, not a new capture.
//  N=1: every beat has m_last=1 and m_idx=0.
// TESTING
//  - N=2, W=32, en=1, win_len=10, plus[0] held 1, m_ready=1 -> cnt_clr pulses every 10 cycles. Steady state: word0=8, word1=0, idx 0 then 1, m_last on idx 1, m_valid first high 1 cycle after terminal count.
//  - en=0, snap_req pulse, counters={32'd7,32'd5} -> cnt_clr in the next cycle; stream words 5 then 7; ovf_cnt stays 0.
//  - m_ready=0 for 30 cycles with win_len=10 -> m_valid held, data stable, 3 events ignored, ovf_cnt=3, cnt_clr still pulsed 3 times. Release ready -> original snapshot delivered.
//  - snap_req on the timer terminal cycle -> exactly one cnt_clr and one stream; timer restarts at 0.
//  - rst_n low mid-stream (m_idx=1, async, not clock-aligned) -> m_valid, busy, cnt_clr, ovf_cnt drop to 0 immediately. After release, the timer restarts from 0.
//  - win_len=0, en=1 for 100 cycles -> no cnt_clr and no m_valid. Force ovf to 16'hFFFF, then one more overflow -> holds at 16'hFFFF.

Source files
------------

// File: rtl/args_counter_sched.sv
// Window scheduler for an N x W-bit event counter bank: ends counting windows
// periodically or on demand, pulses the bank clear, snapshots the counts and
// streams them out one word per beat on a valid/ready interface.
module args_counter_sched #(
  parameter int unsigned N  = 2,
  parameter int unsigned W  = 32,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [W-1:0]   win_len,
  input  logic           snap_req,
  input  logic [N*W-1:0] counters,
  output logic           cnt_clr,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_data,
  output logic [IW-1:0]  m_idx,
  output logic           m_last,
  output logic           busy,
  output logic [15:0]    ovf_cnt
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   timer_q, timer_d;
  logic [W-1:0]   shadow_q [N];
  logic [W-1:0]   shadow_d [N];
  logic [IW-1:0]  idx_q, idx_d;
  logic           clr_q, clr_d;
  logic [15:0]    ovf_q, ovf_d;

  logic           tc;
  logic           win_event;
  logic           idx_end;
  logic           hs;

  // Window event: timer terminal count or software snapshot request
  always_comb begin
    tc        = en && (win_len != '0) && (timer_q == win_len - W'(1));
    win_event = tc || snap_req;
  end

  // Timer next state; any event (including snap_req) restarts the window
  always_comb begin
    timer_d = timer_q + W'(1);
    if (!en || (win_len == '0) || win_event) begin
      timer_d = '0;
    end
  end

  // Capture/stream FSM next state, clear pulse and overflow accounting
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    clr_d    = win_event;
    shadow_d = shadow_q;
    idx_end  = (idx_q == IW'(N - 1));
    hs       = (state_q == StSend) && m_ready;
    unique case (state_q)
      StIdle: begin
        if (win_event) begin
          for (int i = 0; i < int'(N); i++) begin
            shadow_d[i] = counters[i*W +: W];
          end
          state_d = StSend;
          idx_d   = '0;
        end
      end
      StSend: begin
        // An event during a stream, even on its final beat, is dropped
        if (win_event && (ovf_q != 16'hFFFF)) begin
          ovf_d = ovf_q + 16'd1;
        end
        if (hs) begin
          if (idx_end) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      clr_q   <= 1'b0;
      ovf_q   <= '0;
      for (int i = 0; i < int'(N); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      clr_q    <= clr_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs come straight from registers, so they are stable under backpressure
  always_comb begin
    busy    = (state_q == StSend);
    m_valid = busy;
    m_idx   = idx_q;
    m_data  = shadow_q[idx_q];
    m_last  = busy && (idx_q == IW'(N - 1));
    cnt_clr = clr_q;
    ovf_cnt = ovf_q;
  end

endmodule

// File: tb/tb_args_counter_sched.sv
// Randomised self-checking bench for args_counter_sched against a queue-based
// model: a snapshot is a queue of pending words, drained one per accepted beat.
module tb_args_counter_sched;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [W-1:0]   win_len = '0;
  logic           snap_req = 1'b0;
  logic [N*W-1:0] counters = '0;
  logic           cnt_clr;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [W-1:0]   m_data;
  logic [IW-1:0]  m_idx;
  logic           m_last;
  logic           busy;
  logic [15:0]    ovf_cnt;

  args_counter_sched #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .win_len  (win_len),
    .snap_req (snap_req),
    .counters (counters),
    .cnt_clr  (cnt_clr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_idx    (m_idx),
    .m_last   (m_last),
    .busy     (busy),
    .ovf_cnt  (ovf_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  longint unsigned mt;
  logic [W-1:0]    mq[$];
  int unsigned     movf;
  bit              mclr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mt   = 0;
    mq   = {};
    movf = 0;
    mclr = 1'b0;
  endtask

  task automatic check_outputs();
    bit act;
    act = (mq.size() != 0);
    check("m_valid", 64'(m_valid), 64'(act));
    check("busy", 64'(busy), 64'(act));
    check("cnt_clr", 64'(cnt_clr), 64'(mclr));
    check("ovf_cnt", 64'(ovf_cnt), 64'(movf));
    if (act) begin
      check("m_data", 64'(m_data), 64'(mq[0]));
      check("m_idx", 64'(m_idx), 64'(N - mq.size()));
      check("m_last", 64'(m_last), 64'(mq.size() == 1));
    end else begin
      check("m_last_idle", 64'(m_last), 64'(0));
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rise
  task automatic cycle(input bit chk);
    bit tc, ev, was_busy;
    @(negedge clk);
    if (chk) check_outputs();
    tc       = en && (win_len != 0) && (mt == longint'(win_len) - 1);
    ev       = tc || snap_req;
    was_busy = (mq.size() != 0);
    if (was_busy && m_ready) void'(mq.pop_front());
    if (ev) begin
      if (!was_busy) begin
        for (int i = 0; i < int'(N); i++) mq.push_back(counters[i*W +: W]);
      end else if (movf < 16'hFFFF) begin
        movf++;
      end
    end
    if (!en || win_len == 0 || ev) mt = 0;
    else mt = (mt + 1) % (64'd1 << W);
    mclr = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_counters();
    for (int i = 0; i < int'(N); i++) counters[i*W +: W] = $urandom;
  endtask

  int unsigned clr_seen;
  int unsigned budget;
  logic [W-1:0] held;

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1);

    // On-demand snapshot with en=0
    win_len = 10; counters = {32'd7, 32'd5}; snap_req = 1'b1; m_ready = 1'b1;
    cycle(1);
    snap_req = 1'b0;
    check("snap_clr", 64'(cnt_clr), 64'd1);
    check("snap_w0", 64'(m_data), 64'd5);
    check("snap_i0", 64'(m_idx), 64'd0);
    cycle(1);
    check("snap_w1", 64'(m_data), 64'd7);
    check("snap_last", 64'(m_last), 64'd1);
    check("snap_clr_once", 64'(cnt_clr), 64'd0);
    cycle(1);
    check("snap_done", 64'(m_valid), 64'd0);
    check("snap_ovf", 64'(ovf_cnt), 64'd0);

    // Backpressure: stream held while three periodic events are dropped
    m_ready = 1'b0; en = 1'b1; snap_req = 1'b1; counters = {32'hA5A5_0001, 32'h1234_5678};
    cycle(1);
    snap_req = 1'b0; rand_counters();
    clr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1);
      if (cnt_clr) clr_seen++;
    end
    check("stall_ovf", 64'(ovf_cnt), 64'd3);
    check("stall_clr", 64'(clr_seen), 64'd3);
    check("stall_data", 64'(m_data), 64'h1234_5678);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1);

    // Periodic windows disabled by win_len=0
    win_len = 0; clr_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1);
      if (cnt_clr || m_valid) clr_seen++;
    end
    check("wl0_quiet", 64'(clr_seen), 64'd0);

    // Random traffic; win_len only changes while en=0
    for (int ph = 0; ph < 12; ph++) begin
      en = 1'b0;
      win_len = W'($urandom_range(0, 6));
      if (ph % 3 == 0) win_len = 10;
      cycle(1);
      en = 1'b1;
      for (int i = 0; i < 150; i++) begin
        rand_counters();
        snap_req = ($urandom_range(0, 15) == 0);
        m_ready  = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 49) == 0) en = ~en;
        cycle(1);
      end
      snap_req = 1'b0;
    end

    // Asynchronous reset mid-stream at m_idx=1
    en = 1'b0; m_ready = 1'b1; win_len = 10;
    for (int i = 0; i < 4; i++) cycle(1);
    snap_req = 1'b1; cycle(1); snap_req = 1'b0; cycle(1);
    m_ready = 1'b0;
    check("pre_rst_idx", 64'(m_idx), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clr", 64'(cnt_clr), 64'd0);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    // Timer restarts from 0: first terminal count after exactly win_len cycles
    en = 1'b1; m_ready = 1'b1; budget = 0;
    while (!cnt_clr && budget < 40) begin
      cycle(1);
      budget++;
    end
    check("rst_timer_restart", 64'(budget), 64'd10);

    // Overflow counter saturation
    en = 1'b0; m_ready = 1'b0; snap_req = 1'b1;
    for (int i = 0; i < 65540; i++) cycle(0);
    cycle(1);
    check("ovf_sat", 64'(ovf_cnt), 64'hFFFF);
    held = m_data;
    cycle(1);
    check("ovf_hold", 64'(ovf_cnt), 64'hFFFF);
    check("ovf_data_stable", 64'(m_data), 64'(held));
    snap_req = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
